div_unit: RTL and testbench

//  Iterative 32-bit divider for DIV/DIVU; upstream producer of the hi/lo register write ports.

---
 rtl/div_unit_pkg.sv | 10 +
 rtl/div_unit_step.sv | 17 +
 rtl/div_unit.sv | 86 ++++++++
 tb/tb_div_unit.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared widths and FSM state encoding for the iterative divider
package div_unit_pkg;
  localparam int DIV_WIDTH = 32;
  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_DBZ  = 2'b01,
    DIV_ON   = 2'b10,
    DIV_END  = 2'b11
  } div_state_e;
endpackage

// File: rtl/div_unit_step.sv
// div_unit_step: one combinational restoring-division step on the {rem,quot} work register
module div_unit_step
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [2*WIDTH:0] work_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [2*WIDTH:0] work_o
);
  logic [2*WIDTH:0] shifted;
  logic [WIDTH:0]   diff;
  assign shifted = work_i << 1;
  assign diff    = shifted[2*WIDTH:WIDTH] - {1'b0, divisor_i};
  // A borrow means the partial remainder is below the divisor: keep it, quotient bit 0
  assign work_o  = diff[WIDTH] ? shifted : {diff, shifted[WIDTH-1:1], 1'b1};
endmodule

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for DIV/DIVU feeding the hi/lo register
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic             annul_i,
  input  logic [WIDTH-1:0] opdata1_i,
  input  logic [WIDTH-1:0] opdata2_i,
  output logic             busy_o,
  output logic             ready_o,
  output logic             hi_we_o,
  output logic             lo_we_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);
  localparam int CW = $clog2(WIDTH);
  div_state_e       state_q;
  logic [CW-1:0]    cnt_q;
  logic [2*WIDTH:0] work_q, work_d;
  logic [WIDTH-1:0] divisor_q, op1_abs, op2_abs;
  logic             neg_quot_q, neg_rem_q, ready_q;
  logic             op1_neg, op2_neg, dbz, accept;
  assign op1_neg = signed_i & opdata1_i[WIDTH-1];
  assign op2_neg = signed_i & opdata2_i[WIDTH-1];
  assign op1_abs = op1_neg ? -opdata1_i : opdata1_i;
  assign op2_abs = op2_neg ? -opdata2_i : opdata2_i;
  assign dbz     = opdata2_i == '0;
  // A new operation may start from IDLE or on the edge that leaves END
  assign accept  = start_i & ~annul_i & (state_q == DIV_IDLE | state_q == DIV_END);
  assign busy_o  = state_q != DIV_IDLE;
  assign ready_o = ready_q;
  assign hi_we_o = ready_q;
  assign lo_we_o = ready_q;
  div_unit_step #(.WIDTH(WIDTH)) u_step (
    .work_i    (work_q),
    .divisor_i (divisor_q),
    .work_o    (work_d)
  );
  // Divider FSM: latch operands, iterate, fix up signs and publish the result once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= DIV_IDLE;
      cnt_q      <= '0;
      work_q     <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      ready_q    <= 1'b0;
      hi_o       <= '0;
      lo_o       <= '0;
    end else begin
      ready_q <= 1'b0;
      if (annul_i) begin
        state_q <= DIV_IDLE;
      end else begin
        if (state_q == DIV_END) begin
          ready_q <= 1'b1;
          hi_o    <= neg_rem_q ? -work_q[2*WIDTH-1:WIDTH] : work_q[2*WIDTH-1:WIDTH];
          lo_o    <= neg_quot_q ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
          state_q <= DIV_IDLE;
        end
        if (accept) begin
          state_q    <= dbz ? DIV_DBZ : DIV_ON;
          cnt_q      <= '0;
          // Divide-by-zero keeps the raw dividend so it can be returned as the remainder
          work_q     <= {{(WIDTH+1){1'b0}}, dbz ? opdata1_i : op1_abs};
          divisor_q  <= op2_abs;
          neg_quot_q <= ~dbz & (op1_neg ^ op2_neg);
          neg_rem_q  <= ~dbz & op1_neg;
        end else if (state_q == DIV_DBZ) begin
          work_q  <= {1'b0, work_q[WIDTH-1:0], {WIDTH{1'b1}}};
          state_q <= DIV_END;
        end else if (state_q == DIV_ON) begin
          work_q  <= work_d;
          cnt_q   <= cnt_q + 1'b1;
          state_q <= (cnt_q == CW'(WIDTH-1)) ? DIV_END : DIV_ON;
        end
      end
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed checks of div_unit against an arithmetic reference model
module tb_div_unit;
  logic        clk = 1'b0, rst = 1'b0, start_i = 1'b0, signed_i = 1'b0, annul_i = 1'b0;
  logic [31:0] opdata1_i = '0, opdata2_i = '0;
  logic        busy_o, ready_o, hi_we_o, lo_we_o;
  logic [31:0] hi_o, lo_o;
  int          checks = 0, fails = 0, we_cnt = 0;
  int          m_left = 0;
  logic        m_ready = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;

  div_unit dut (
    .clk(clk), .rst(rst), .start_i(start_i), .signed_i(signed_i), .annul_i(annul_i),
    .opdata1_i(opdata1_i), .opdata2_i(opdata2_i), .busy_o(busy_o), .ready_o(ready_o),
    .hi_we_o(hi_we_o), .lo_we_o(lo_we_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference results straight from integer arithmetic
  function automatic void calc(input logic [31:0] a, input logic [31:0] b, input logic s,
                               output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    sa = s ? longint'($signed(a)) : longint'(a);
    sb = s ? longint'($signed(b)) : longint'(b);
    if (b == 0) begin
      q = '1;
      r = a;
    end else begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end
  endfunction

  // Cycle model: an accepted op completes 33 edges later (2 for divide by zero)
  always @(posedge clk or negedge rst) begin
    int prev;
    if (!rst) begin
      m_left = 0; m_ready = 1'b0; m_hi = '0; m_lo = '0;
    end else begin
      m_ready = 1'b0;
      prev = m_left;
      if (annul_i) m_left = 0;
      else begin
        if (prev == 1) begin m_ready = 1'b1; m_hi = p_hi; m_lo = p_lo; end
        if (prev > 0) m_left = prev - 1;
        if (start_i && prev <= 1) begin
          calc(opdata1_i, opdata2_i, signed_i, p_lo, p_hi);
          m_left = (opdata2_i == 0) ? 2 : 33;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("busy", 32'(busy_o), 32'(m_left != 0));
      chk("ready", 32'(ready_o), 32'(m_ready));
      chk("hi_we", 32'(hi_we_o), 32'(m_ready));
      chk("lo_we", 32'(lo_we_o), 32'(m_ready));
      chk("hi", hi_o, m_hi);
      chk("lo", lo_o, m_lo);
      if (hi_we_o) we_cnt++;
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    start_i = 1'b1; opdata1_i = a; opdata2_i = b; signed_i = s;
    @(negedge clk);
    start_i = 1'b0; opdata1_i = 32'hDEAD_BEEF; opdata2_i = '0; signed_i = ~s;
  endtask

  task automatic wait_rdy(output int cyc);
    cyc = 0;
    while (!ready_o && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    if (!ready_o) chk("ready timeout", 32'(ready_o), 32'd1);
  endtask

  task automatic run(input string n, input logic [31:0] a, input logic [31:0] b, input logic s,
                     input logic [31:0] eq, input logic [31:0] er, input int elat);
    int cyc;
    issue(a, b, s);
    wait_rdy(cyc);
    chk({n, " latency"}, 32'(cyc), 32'(elat));
    chk({n, " lo"}, lo_o, eq);
    chk({n, " hi"}, hi_o, er);
  endtask

  initial begin
    logic [31:0] q, r;
    int cyc;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset busy", 32'(busy_o), 32'd0);
    chk("reset ready", 32'(ready_o), 32'd0);
    chk("reset hi", hi_o, 32'd0);
    chk("reset lo", lo_o, 32'd0);
    calc(32'hFFFF_FFF9, 32'd2, 1'b1, q, r);
    chk("model neg q", q, 32'hFFFF_FFFD);
    chk("model neg r", r, 32'hFFFF_FFFF);
    calc(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, q, r);
    chk("model ovf q", q, 32'h8000_0000);
    run("divu 100/7", 32'd100, 32'd7, 1'b0, 32'hE, 32'h2, 33);
    run("div -7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    run("div min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0, 33);
    run("div 7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'h1, 33);
    run("divu dbz", 32'h1234, 32'h0, 1'b0, 32'hFFFF_FFFF, 32'h1234, 2);
    issue(32'd100, 32'd3, 1'b0);
    repeat (10) @(negedge clk);
    annul_i = 1'b1;
    @(negedge clk);
    annul_i = 1'b0;
    chk("annul busy", 32'(busy_o), 32'd0);
    chk("annul hi", hi_o, 32'h1234);
    chk("annul lo", lo_o, 32'hFFFF_FFFF);
    annul_i = 1'b1; start_i = 1'b1; opdata1_i = 32'd5; opdata2_i = 32'd1;
    @(negedge clk);
    annul_i = 1'b0; start_i = 1'b0;
    chk("annul+start busy", 32'(busy_o), 32'd0);
    repeat (40) @(negedge clk);
    chk("annul we count", 32'(we_cnt), 32'd5);
    run("divu 9/2", 32'd9, 32'd2, 1'b0, 32'd4, 32'd1, 33);
    issue(32'd1000, 32'd10, 1'b0);
    repeat (5) @(negedge clk);
    start_i = 1'b1; opdata1_i = 32'd7; opdata2_i = 32'd7;
    @(negedge clk);
    start_i = 1'b0;
    wait_rdy(cyc);
    chk("ignored start lo", lo_o, 32'd100);
    chk("ignored start hi", hi_o, 32'd0);
    run("divu max/1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'h0, 33);
    issue(32'd50, 32'd5, 1'b0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async rst busy", 32'(busy_o), 32'd0);
    chk("async rst ready", 32'(ready_o), 32'd0);
    chk("async rst hi", hi_o, 32'd0);
    chk("async rst lo", lo_o, 32'd0);
    @(negedge clk);
    #1 rst = 1'b1;
    run("after rst 77/8", 32'd77, 32'd8, 1'b0, 32'd9, 32'd5, 33);
    repeat (3) @(negedge clk);
    chk("total we pulses", 32'(we_cnt), 32'd9);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
